// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with imem req/ack, stall, flush and skid buffer
//
// Purpose:
//   Owns the fetch PC and issues one instruction-memory request at a time.
//   Presents one registered instruction, its PC and its opcode field to decode.
//   A one-entry skid buffer catches a response that arrives while decode is
//   stalled, so no fetched instruction is ever lost.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active-low
//   start_i        leave IDLE and begin fetching
//   imem_req_o     instruction memory request (high exactly in REQ)
//   imem_addr_o    request address, equals the fetch PC
//   imem_ack_i     request accepted, imem_data_i valid in the same cycle
//   imem_data_i    fetched instruction word
//   stall_i        decode cannot accept this cycle
//   flush_i        discard held/in-flight instructions, redirect the PC
//   redirect_pc_i  new fetch PC, sampled while flush_i=1
//   instr_valid_o  instr_o/pc_o/op_o hold a real instruction
//   instr_o        instruction to decode (NOP_INSTR while not valid)
//   pc_o           PC of instr_o
//   op_o           instr_o[6:0]
//
// Optional build macro FETCH_PERF_CNT_EN adds:
//   fetch_cnt_o    count of accepted, non-discarded acks (wraps)
//   stall_cnt_o    count of cycles with a valid instruction held under stall (wraps)

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [6:0]  op_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  // Target to use once the request outstanding at flush time has been acked.
  logic [31:0] redirect_q, redirect_d;
  logic        discard_q, discard_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;

  // The skid entry is occupied exactly while the FSM sits in HOLD, so it
  // needs no separate valid bit.
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic ack_live;
  logic consumed;

  assign ack_live = imem_ack_i && (state_q == S_REQ);
  assign consumed = out_valid_q && !stall_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirect_d   = redirect_q;
    discard_d    = discard_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (consumed) begin
      out_valid_d = 1'b0;
    end

    if (flush_i) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          pc_d = redirect_pc_i;
        end
        if (start_i) begin
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (flush_i) begin
          if (ack_live) begin
            // The outstanding request completes now; its data is dropped.
            pc_d      = redirect_pc_i;
            discard_d = 1'b0;
          end else begin
            // Request must stay stable until acked; drop its data later.
            discard_d  = 1'b1;
            redirect_d = redirect_pc_i;
          end
        end else if (ack_live) begin
          if (discard_q) begin
            pc_d      = redirect_q;
            discard_d = 1'b0;
          end else if (!out_valid_q || !stall_i) begin
            out_valid_d = 1'b1;
            out_instr_d = imem_data_i;
            out_pc_d    = pc_q;
            pc_d        = pc_q + 32'd4;
          end else begin
            skid_instr_d = imem_data_i;
            skid_pc_d    = pc_q;
            pc_d         = pc_q + 32'd4;
            state_d      = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (flush_i) begin
          pc_d    = redirect_pc_i;
          state_d = S_REQ;
        end else if (consumed) begin
          out_valid_d = 1'b1;
          out_instr_d = skid_instr_q;
          out_pc_d    = skid_pc_q;
          state_d     = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Keep the output register at NOP whenever nothing valid is held.
    if (!out_valid_d) begin
      out_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      redirect_q   <= RESET_PC;
      discard_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP_INSTR;
      out_pc_q     <= 32'h0000_0000;
      skid_instr_q <= 32'h0000_0000;
      skid_pc_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      discard_q    <= discard_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign imem_req_o    = (state_q == S_REQ);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = out_valid_q;
  assign instr_o       = out_instr_q;
  assign pc_o          = out_pc_q;
  assign op_o          = out_instr_q[6:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_q <= 32'h0000_0000;
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      // An ack coinciding with a flush, or landing while discarding, is dropped.
      if (ack_live && !discard_q && !flush_i) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (out_valid_q && stall_i) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the opcode decoder/control unit.
- Owns the fetch PC and runs a req/ack handshake to instruction memory, one request outstanding at a time.
- Presents one registered instruction, its PC and its 7-bit opcode field to decode.
- Supports downstream stall, flush/redirect, and a 1-entry skid buffer so an in-flight response is never lost.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction driven on instr_o while no valid instruction is held (addi x0,x0,0)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
start_i  input  1  leave IDLE and begin fetching
imem_req_o  output  1  instruction memory request
imem_addr_o  output  32  request address; equals fetch PC
imem_ack_i  input  1  request accepted; imem_data_i valid in this same cycle
imem_data_i  input  32  fetched instruction word
stall_i  input  1  decode cannot accept this cycle
flush_i  input  1  discard all held/in-flight instructions, redirect PC
redirect_pc_i  input  32  new fetch PC, sampled when flush_i=1
instr_valid_o  output  1  instr_o/pc_o/op_o hold a real instruction
instr_o  output  32  instruction to decode
pc_o  output  32  PC of instr_o
op_o  output  7  instr_o[6:0], to control unit

Behaviour:
- Reset (rst_i=0, async) forces:
  - state=IDLE, fetch PC=RESET_PC
  - imem_req_o=0, imem_addr_o=RESET_PC
  - instr_valid_o=0, instr_o=NOP_INSTR, pc_o=0, op_o=7'b0010011
  - skid buffer empty, discard flag=0
- Consumption: the output slot is consumed in any cycle with instr_valid_o=1 and stall_i=0.
- Request contract:
  - imem_req_o=1 exactly in state REQ.
  - imem_addr_o stays stable until the cycle in which imem_ack_i=1.
  - imem_ack_i is ignored while imem_req_o=0.
- States:
  - IDLE:
    - req=0.
    - start_i=1 -> REQ next cycle.
    - flush_i in IDLE only loads fetch PC.
  - REQ, on ack with discard=0:
    - If the output slot is empty or consumed this cycle: load instr_o=imem_data_i, pc_o=fetch PC, instr_valid_o=1. Fetch PC += 4, stay in REQ (back-to-back, one instruction per cycle at zero-wait memory).
    - Otherwise: write data and PC into the skid buffer, fetch PC += 4, go to HOLD.
  - HOLD:
    - req=0.
    - When the output is consumed, the skid entry moves to the output next edge; skid empties and state returns to REQ.
- Flush (priority over stall and ack):
  - Next edge: instr_valid_o=0, skid emptied, fetch PC=redirect_pc_i.
  - HOLD -> REQ.
  - If in REQ and the ack is not in the flush cycle: keep req/addr stable, set discard=1. The next ack's data is dropped, discard is cleared, and the following cycle requests redirect_pc_i.
  - If the ack coincides with flush_i: data is dropped and fetch PC=redirect_pc_i (no +4).
  - Flush while discard=1 just updates the redirect target.
- Output mapping:
  - op_o is always instr_o[6:0].
  - While instr_valid_o=0, instr_o=NOP_INSTR.
- Fetch PC arithmetic is 32-bit modulo; 0xFFFF_FFFC+4 wraps to 0.
- Reset mid-request: the request is abandoned immediately; a late ack after reset is ignored (state IDLE).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt_o[31:0] and stall_cnt_o[31:0], both reset to 0.
  - fetch_cnt_o increments on each non-discarded ack.
  - stall_cnt_o increments each cycle with instr_valid_o=1 and stall_i=1.
  - Both wrap modulo 2^32 and are unaffected by flush.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then start_i pulse, memory acks every cycle with data=addr^32'hA5A5_0000 -> imem_addr_o 0,4,8,...; instr_valid_o=1 from the 2nd cycle after start; pc_o/instr_o pair match; op_o=data[6:0].
- stall_i=1 for 3 cycles during streaming -> one ack enters skid, imem_req_o drops; after release, skid instruction appears next, no instruction lost or duplicated.
- flush_i with redirect 0x100 while a request to 0x20 is pending, ack 2 cycles later -> 0x20 data never presented; next request address 0x100.
- flush_i in same cycle as ack -> data dropped, next imem_addr_o=redirect_pc_i, instr_valid_o=0 for that cycle.
- Assert rst_i=0 mid-stream (asynchronously, between edges) -> outputs at reset values immediately, instr_o=32'h0000_0013, op_o=7'b0010011.
- With FETCH_PERF_CNT_EN: 10 acks, 4 stall cycles -> fetch_cnt_o=10, stall_cnt_o=4.
